bit_counter_nb: RTL
===================

BIT_COUNTER_NB -- requirements
Module: bit_counter_nb

Interface
REQ-001 SHALL have parameter WIDTH, default 16, input data width in bits; legal range 2..64.
REQ-002 SHALL have local parameter CW = $clog2(WIDTH+1), result width.
REQ-003 SHALL have port i_clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 SHALL have port i_rst  input  1  reset; synchronous, active-high.
REQ-005 SHALL have port i_start  input  1  request; sampled only in IDLE.
REQ-006 SHALL have port i_mode  input  2  operation: 00 count ones, 01 count zeros, 10 leading zeros (from MSB), 11 trailing zeros (from LSB).
REQ-007 SHALL have port i_data  input  WIDTH  operand; captured with i_start.
REQ-008 SHALL have port o_busy  output  1  high while in COUNT.
REQ-009 SHALL have port o_done  output  1  one-cycle pulse; result valid.
REQ-010 SHALL have port o_result  output  CW  result; held until next DONE.

Function
REQ-011 SHALL implement a 3-state FSM: IDLE, COUNT, DONE.
REQ-012 IDLE with i_start=1 SHALL load a WIDTH-bit shift register with i_data, latch i_mode, clear the internal count and bit index, and go to COUNT; i_start=0 SHALL stay in IDLE.
REQ-013 i_start SHALL be ignored in COUNT and DONE; i_data and i_mode changes after capture SHALL have no effect.
REQ-014 Modes 00/01, per COUNT cycle: if shift register == 0 go to DONE; else count += sreg[0] and sreg shifts right with 0 fill.
REQ-015 Modes 00/01 latency: o_done SHALL assert at edge msb_idx+3 after the start-sampling edge, or at edge 2 when data == 0 (early termination).
REQ-016 Mode 00 SHALL produce result = count; mode 01 SHALL produce result = WIDTH - count, computed in CW bits.
REQ-017 Mode 10, per COUNT cycle: if sreg[WIDTH-1] == 1 or bit index == WIDTH go to DONE; else count++, index++, sreg shifts left with 0 fill.
REQ-018 Mode 11 SHALL follow REQ-017 using sreg[0] and a right shift.
REQ-019 Modes 10/11 latency: o_done SHALL assert at edge result+2; an all-zero operand SHALL give result WIDTH at edge WIDTH+2.
REQ-020 o_result SHALL update only on the edge entering DONE and hold through IDLE until the next DONE entry.
REQ-021 DONE SHALL last exactly one cycle with o_done=1, then return to IDLE unconditionally.
REQ-022 A new i_start SHALL be accepted no earlier than the first IDLE cycle after DONE.
REQ-023 The count SHALL never exceed WIDTH; CW SHALL represent WIDTH without overflow, including WIDTH a power of two.

Reset
REQ-024 i_rst=1 at a rising edge SHALL force IDLE and clear o_busy, o_done, o_result, count, index and shift register to 0, in any state.
REQ-025 Reset mid-COUNT SHALL abort the operation with no o_done pulse; o_result SHALL read 0.
REQ-026 i_rst SHALL take priority over a simultaneous i_start.

Verification (WIDTH=16)
REQ-027 SHALL check mode 00, i_data=16'hB00F -> o_result=7, o_done at edge 18, o_busy high edges 1..17.
REQ-028 SHALL check mode 00, i_data=16'h0000 -> o_result=0, o_done at edge 2; then mode 01, i_data=16'h00F0 -> o_result=12 at edge 10.
REQ-029 SHALL check mode 10, i_data=16'h0100 -> o_result=7 at edge 9; and mode 10, i_data=16'h0000 -> o_result=16 at edge 18.
REQ-030 SHALL check mode 11, i_data=16'h8000 -> o_result=15 at edge 17; a second i_start pulsed during COUNT SHALL produce no second run.
REQ-031 SHALL check reset asserted 5 cycles into a mode-00 run of 16'hFFFF -> IDLE next edge, o_result=0, no o_done; a fresh start SHALL then return 16 at edge 18.
REQ-032 SHALL check back-to-back operation: i_start held high continuously -> runs separated by at least one IDLE cycle, each result correct.

Source files
------------

// File: rtl/bit_counter_nb.sv
// bit_counter_nb: multi-cycle bit counter. It counts ones or zeros, or
// leading or trailing zeros, of a captured operand one bit per cycle.
// The result is held on o_result until the next completion.
module bit_counter_nb #(
  parameter  int WIDTH = 16,
  localparam int CW    = $clog2(WIDTH + 1)
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_start,
  input  logic [1:0]       i_mode,
  input  logic [WIDTH-1:0] i_data,
  output logic             o_busy,
  output logic             o_done,
  output logic [CW-1:0]    o_result
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    COUNT = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam logic [CW-1:0] WIDTH_CW = CW'(WIDTH);

  state_t           state;
  state_t           next;
  logic [WIDTH-1:0] sreg;
  logic [1:0]       mode_q;
  logic [CW-1:0]    count;
  logic [CW-1:0]    idx;
  logic             finish;
  logic [CW-1:0]    final_result;

  // State register; reset takes priority over any start request
  always_ff @(posedge i_clk) begin
    if (i_rst) state <= IDLE;
    else       state <= next;
  end

  // Next-state, termination test, result selection and status outputs
  always_comb begin
    next         = state;
    o_busy       = 1'b0;
    o_done       = 1'b0;
    finish       = 1'b0;
    final_result = count;

    // Population modes stop once no set bits remain, so the loop length
    // tracks the highest set bit rather than the full width.
    case (mode_q)
      2'b00, 2'b01: finish = (sreg == '0);
      2'b10:        finish = sreg[WIDTH-1] || (idx == WIDTH_CW);
      default:      finish = sreg[0]       || (idx == WIDTH_CW);
    endcase

    if (mode_q == 2'b01) final_result = WIDTH_CW - count;

    case (state)
      IDLE: begin
        if (i_start) next = COUNT;
      end
      COUNT: begin
        o_busy = 1'b1;
        if (finish) next = DONE;
      end
      DONE: begin
        o_done = 1'b1;
        next   = IDLE;
      end
      default: next = IDLE;
    endcase
  end

  // Datapath: operand capture, per-cycle shift/count and result latch
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      sreg     <= '0;
      mode_q   <= '0;
      count    <= '0;
      idx      <= '0;
      o_result <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (i_start) begin
            sreg   <= i_data;
            mode_q <= i_mode;
            count  <= '0;
            idx    <= '0;
          end
        end
        COUNT: begin
          if (finish) begin
            o_result <= final_result;
          end else begin
            case (mode_q)
              2'b00, 2'b01: begin
                count <= count + CW'(sreg[0]);
                sreg  <= sreg >> 1;
              end
              2'b10: begin
                count <= count + 1'b1;
                idx   <= idx + 1'b1;
                sreg  <= sreg << 1;
              end
              default: begin
                count <= count + 1'b1;
                idx   <= idx + 1'b1;
                sreg  <= sreg >> 1;
              end
            endcase
          end
        end
        default: ;
      endcase
    end
  end

endmodule
